man_dead_sprite_fetch: RTL and testbench

Upstream feeder for the dead-man palette stage. Runs the death-animation state machine off the vertical sync and computes the sprite-BRAM word address for the current pixel, 8 four-bit pixels per 32-bit word, 20x20 sprite, 50 words per frame. Delays the draw and sprite coordinates to match the address register plus the synchronous BRAM read latency. The palette stage therefore receives coordinates and `man_data` aligned on the same cycle.

---
 rtl/man_dead_sprite_fetch.sv | 205 ++++++++++++++++++++
 tb/tb_man_dead_sprite_fetch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/man_dead_sprite_fetch.sv
// rtl/man_dead_sprite_fetch.sv - death-animation sequencer and sprite BRAM address generator
//
// Purpose:
//   Runs the ALIVE / DYING / DEAD_HOLD animation state machine off falling
//   edges of the active-low vertical sync. Computes the sprite BRAM word
//   address for the current pixel. Each word holds 8 four-bit pixels, the
//   sprite is 20x20, and each frame is 50 words. The draw/sprite coordinates
//   and the in-box flag are delayed two cycles so they line up with the
//   BRAM read data.
//
// Ports:
//   Clk        in   pixel clock
//   Reset      in   asynchronous active-high reset
//   vs         in   vertical sync, active-low; a 1->0 edge is one frame tick
//   dead       in   player-dead level
//   DrawX/Y    in   current pixel coordinates (10 bits)
//   ManX/Y     in   sprite top-left coordinates (10 bits)
//   man_addr   out  registered BRAM word address (one cycle after inputs)
//   DrawX_d..  out  coordinates delayed two cycles
//   man_on_d   out  pixel inside sprite box while not ALIVE, delayed two cycles
//   anim_done  out  high while holding the last frame
module man_dead_sprite_fetch #(
  parameter int FRAMES        = 4,
  parameter int FRAME_VBLANKS = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic       dead,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic [9:0] ManX,
  input  logic [9:0] ManY,
  output logic [7:0] man_addr,
  output logic [9:0] DrawX_d,
  output logic [9:0] DrawY_d,
  output logic [9:0] ManX_d,
  output logic [9:0] ManY_d,
  output logic       man_on_d,
  output logic       anim_done
);

  localparam logic [1:0] ST_ALIVE = 2'd0;
  localparam logic [1:0] ST_DYING = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [7:0]  FRAME_LAST      = 8'(FRAMES - 1);
  localparam logic [15:0] VCNT_LAST       = 16'(FRAME_VBLANKS - 1);
  localparam logic [7:0]  WORDS_PER_FRAME = 8'd50;
  localparam logic [10:0] SPRITE_SIZE     = 11'd20;

  // ---------------------------------------------------------------------
  // Frame tick: falling edge of vs. vs_q resets high so a vs held low
  // through reset release still yields exactly one tick.
  // ---------------------------------------------------------------------
  logic vs_q;
  logic tick;

  assign tick = vs_q & ~vs;

  // ---------------------------------------------------------------------
  // Animation state machine
  // ---------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [7:0]  frame_q, frame_d;
  logic [15:0] vcnt_q,  vcnt_d;
  logic        anim_done_q;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    vcnt_d  = vcnt_q;
    if (!dead) begin
      // Leaving the dead condition wins over everything, including a tick.
      state_d = ST_ALIVE;
      frame_d = 8'd0;
      vcnt_d  = 16'd0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          // A tick coinciding with entry is deliberately not counted.
          state_d = ST_DYING;
          frame_d = 8'd0;
          vcnt_d  = 16'd0;
        end
        ST_DYING: begin
          if (tick) begin
            if (vcnt_q == VCNT_LAST) begin
              vcnt_d = 16'd0;
              if (frame_q < FRAME_LAST) begin
                frame_d = frame_q + 8'd1;
              end else begin
                state_d = ST_HOLD;
              end
            end else begin
              vcnt_d = vcnt_q + 16'd1;
            end
          end
        end
        ST_HOLD: begin
          state_d = ST_HOLD;
        end
        default: begin
          state_d = ST_ALIVE;
          frame_d = 8'd0;
          vcnt_d  = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q        <= 1'b1;
      state_q     <= ST_ALIVE;
      frame_q     <= 8'd0;
      vcnt_q      <= 16'd0;
      anim_done_q <= 1'b0;
    end else begin
      vs_q        <= vs;
      state_q     <= state_d;
      frame_q     <= frame_d;
      vcnt_q      <= vcnt_d;
      // Registered from the next state so it rises on the entering edge.
      anim_done_q <= (state_d == ST_HOLD);
    end
  end

  assign anim_done = anim_done_q;

  // ---------------------------------------------------------------------
  // Box test and address. Comparisons are done in 11 bits so a sprite near
  // the right/bottom edge never wraps back onto low coordinates.
  // ---------------------------------------------------------------------
  logic [10:0] draw_x_ext, draw_y_ext, man_x_ext, man_y_ext;
  logic        in_box;
  logic [4:0]  off_x, off_y;
  logic [8:0]  local_idx;
  logic [5:0]  word_idx;
  logic [7:0]  addr_d;

  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};
  assign man_x_ext  = {1'b0, ManX};
  assign man_y_ext  = {1'b0, ManY};

  assign in_box = (man_x_ext <= draw_x_ext) && (draw_x_ext < man_x_ext + SPRITE_SIZE) &&
                  (man_y_ext <= draw_y_ext) && (draw_y_ext < man_y_ext + SPRITE_SIZE);

  // Offsets are only meaningful inside the box, where they fit in 5 bits.
  assign off_x     = 5'(DrawX - ManX);
  assign off_y     = 5'(DrawY - ManY);
  assign local_idx = 9'(off_y) * 9'd20 + 9'(off_x);
  assign word_idx  = 6'(local_idx >> 3);

  // frame_q is the pre-edge value, so a frame change reaches the address
  // one cycle after the state update.
  assign addr_d = in_box ? (8'(frame_q * WORDS_PER_FRAME) + {2'b00, word_idx}) : 8'd0;

  // ---------------------------------------------------------------------
  // Address register plus two-stage coordinate/flag delay. Stage 1 is in
  // step with man_addr; stage 2 is in step with the BRAM read data.
  // ---------------------------------------------------------------------
  logic [7:0] man_addr_q;
  logic [9:0] draw_x_s1_q, draw_y_s1_q, man_x_s1_q, man_y_s1_q;
  logic       man_on_s1_q;
  logic [9:0] draw_x_s2_q, draw_y_s2_q, man_x_s2_q, man_y_s2_q;
  logic       man_on_s2_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      man_addr_q  <= 8'd0;
      draw_x_s1_q <= 10'd0;
      draw_y_s1_q <= 10'd0;
      man_x_s1_q  <= 10'd0;
      man_y_s1_q  <= 10'd0;
      man_on_s1_q <= 1'b0;
      draw_x_s2_q <= 10'd0;
      draw_y_s2_q <= 10'd0;
      man_x_s2_q  <= 10'd0;
      man_y_s2_q  <= 10'd0;
      man_on_s2_q <= 1'b0;
    end else begin
      man_addr_q  <= addr_d;
      draw_x_s1_q <= DrawX;
      draw_y_s1_q <= DrawY;
      man_x_s1_q  <= ManX;
      man_y_s1_q  <= ManY;
      man_on_s1_q <= in_box && (state_q != ST_ALIVE);
      draw_x_s2_q <= draw_x_s1_q;
      draw_y_s2_q <= draw_y_s1_q;
      man_x_s2_q  <= man_x_s1_q;
      man_y_s2_q  <= man_y_s1_q;
      man_on_s2_q <= man_on_s1_q;
    end
  end

  assign man_addr = man_addr_q;
  assign DrawX_d  = draw_x_s2_q;
  assign DrawY_d  = draw_y_s2_q;
  assign ManX_d   = man_x_s2_q;
  assign ManY_d   = man_y_s2_q;
  assign man_on_d = man_on_s2_q;

endmodule

// File: tb/tb_man_dead_sprite_fetch.sv
// tb/tb_man_dead_sprite_fetch.sv - self-checking bench for man_dead_sprite_fetch
module tb_man_dead_sprite_fetch;

  localparam int F  = 4;
  localparam int FV = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vs = 1'b1;
  logic       dead = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, ManX = '0, ManY = '0;
  logic [7:0] man_addr;
  logic [9:0] DrawX_d, DrawY_d, ManX_d, ManY_d;
  logic       man_on_d, anim_done;

  man_dead_sprite_fetch #(.FRAMES(F), .FRAME_VBLANKS(FV)) dut (
    .Clk(Clk), .Reset(Reset), .vs(vs), .dead(dead),
    .DrawX(DrawX), .DrawY(DrawY), .ManX(ManX), .ManY(ManY),
    .man_addr(man_addr), .DrawX_d(DrawX_d), .DrawY_d(DrawY_d),
    .ManX_d(ManX_d), .ManY_d(ManY_d), .man_on_d(man_on_d), .anim_done(anim_done)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  // Reference model: ticks counted since the animation started.
  int m_T = 0;
  bit m_alive = 1'b1;
  bit m_vsp = 1'b1;

  typedef struct {
    int dx; int dy; int mx; int my; bit on;
  } stage_t;

  stage_t e_s1, e_s2;
  int e_addr = 0;
  bit e_done = 1'b0;

  typedef struct {
    logic [9:0] mx; logic [9:0] my; logic [9:0] dx; logic [9:0] dy;
    int addr; bit on;
  } vec_t;

  vec_t tbl[8];

  function automatic int m_frame();
    int f;
    f = m_T / FV;
    return (f > F - 1) ? F - 1 : f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_T = 0; m_alive = 1'b1; m_vsp = 1'b1;
    e_s1 = '{0, 0, 0, 0, 1'b0};
    e_s2 = '{0, 0, 0, 0, 1'b0};
    e_addr = 0; e_done = 1'b0;
  endtask

  task automatic chk_all();
    chk("man_addr", int'(man_addr), e_addr);
    chk("DrawX_d", int'(DrawX_d), e_s2.dx);
    chk("DrawY_d", int'(DrawY_d), e_s2.dy);
    chk("ManX_d", int'(ManX_d), e_s2.mx);
    chk("ManY_d", int'(ManY_d), e_s2.my);
    chk("man_on_d", int'(man_on_d), int'(e_s2.on));
    chk("anim_done", int'(anim_done), int'(e_done));
  endtask

  // One pixel cycle: drive, clock, advance the model, check everything.
  task automatic cyc(input bit v, input bit d, input logic [9:0] dx, input logic [9:0] dy,
                     input logic [9:0] mx, input logic [9:0] my);
    int ix, iy, jx, jy, lidx, a;
    bit box, tk;
    ix = int'(dx); iy = int'(dy); jx = int'(mx); jy = int'(my);
    vs = v; dead = d; DrawX = dx; DrawY = dy; ManX = mx; ManY = my;
    box = (jx <= ix) && (ix < jx + 20) && (jy <= iy) && (iy < jy + 20);
    lidx = (ix - jx) + (iy - jy) * 20;
    a = box ? m_frame() * 50 + lidx / 8 : 0;
    e_s2 = e_s1;
    e_s1 = '{ix, iy, jx, jy, box && !m_alive};
    e_addr = a;
    @(posedge Clk);
    tk = m_vsp && !v;
    m_vsp = v;
    if (!d) begin
      m_alive = 1'b1; m_T = 0;
    end else if (m_alive) begin
      m_alive = 1'b0; m_T = 0;
    end else if (tk) begin
      m_T++;
    end
    e_done = !m_alive && (m_T >= F * FV);
    #1;
    chk_all();
  endtask

  task automatic pulse(input bit d);
    cyc(1'b0, d, 10'd200, 10'd200, 10'd200, 10'd200);
    cyc(1'b1, d, 10'd200, 10'd200, 10'd200, 10'd200);
  endtask

  task automatic pix(input bit d);
    cyc(1'b1, d, 10'd200, 10'd200, 10'd200, 10'd200);
  endtask

  initial begin
    bit rv, rd;
    logic [9:0] rmx, rmy;

    tbl[0] = '{10'd50,  10'd50,  10'd69,  10'd69,  49, 1'b1};
    tbl[1] = '{10'd50,  10'd50,  10'd50,  10'd50,  0,  1'b1};
    tbl[2] = '{10'd50,  10'd50,  10'd57,  10'd51,  3,  1'b1};
    tbl[3] = '{10'd630, 10'd0,   10'd5,   10'd0,   0,  1'b0};
    tbl[4] = '{10'd100, 10'd100, 10'd120, 10'd100, 0,  1'b0};
    tbl[5] = '{10'd100, 10'd100, 10'd100, 10'd99,  0,  1'b0};
    tbl[6] = '{10'd100, 10'd100, 10'd119, 10'd119, 49, 1'b1};
    tbl[7] = '{10'd0,   10'd0,   10'd19,  10'd0,   2,  1'b1};

    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    chk_all();
    Reset = 1'b0;

    // Release alive, sprite at the pixel: nothing drawn.
    cyc(1'b1, 1'b0, 10'd100, 10'd100, 10'd100, 10'd100);
    cyc(1'b1, 1'b0, 10'd100, 10'd100, 10'd100, 10'd100);
    chk("rel_addr", int'(man_addr), 0);
    chk("rel_on", int'(man_on_d), 0);

    // Exactly two-cycle coordinate delay.
    cyc(1'b1, 1'b0, 10'd7, 10'd0, 10'd0, 10'd0);
    chk("dly_n1", int'(DrawX_d), 100);
    cyc(1'b1, 1'b0, 10'd300, 10'd0, 10'd0, 10'd0);
    chk("dly_n2", int'(DrawX_d), 7);
    cyc(1'b1, 1'b0, 10'd300, 10'd0, 10'd0, 10'd0);
    chk("dly_n3", int'(DrawX_d), 300);

    // Enter DYING at frame 0, then address corners from the table.
    pix(1'b1);
    foreach (tbl[i]) begin
      cyc(1'b1, 1'b1, tbl[i].dx, tbl[i].dy, tbl[i].mx, tbl[i].my);
      chk($sformatf("tbl%0d_addr", i), int'(man_addr), tbl[i].addr);
      cyc(1'b1, 1'b1, tbl[i].dx, tbl[i].dy, tbl[i].mx, tbl[i].my);
      chk($sformatf("tbl%0d_on", i), int'(man_on_d), int'(tbl[i].on));
    end

    // Progression through all frames into the hold.
    repeat (7) pulse(1'b1);
    chk("prog7", int'(man_addr), 0);
    pulse(1'b1);
    chk("prog8", int'(man_addr), 50);
    repeat (23) pulse(1'b1);
    chk("prog31_addr", int'(man_addr), 150);
    chk("prog31_done", int'(anim_done), 0);
    pulse(1'b1);
    chk("prog32_addr", int'(man_addr), 150);
    chk("prog32_done", int'(anim_done), 1);
    repeat (10) pulse(1'b1);
    chk("hold_addr", int'(man_addr), 150);
    chk("hold_done", int'(anim_done), 1);

    // Abort at frame 2 on a tick cycle, then restart from frame 0.
    pix(1'b0);
    pix(1'b1);
    repeat (16) pulse(1'b1);
    chk("f2_addr", int'(man_addr), 100);
    repeat (7) pulse(1'b1);
    cyc(1'b0, 1'b0, 10'd200, 10'd200, 10'd200, 10'd200);
    pix(1'b0);
    pix(1'b0);
    chk("abort_addr", int'(man_addr), 0);
    chk("abort_on", int'(man_on_d), 0);
    chk("abort_done", int'(anim_done), 0);
    pix(1'b1);
    pulse(1'b1);
    chk("restart1", int'(man_addr), 0);
    repeat (7) pulse(1'b1);
    chk("restart8", int'(man_addr), 50);

    // vs held low produces a single tick.
    pix(1'b0);
    pix(1'b1);
    repeat (20) cyc(1'b0, 1'b1, 10'd200, 10'd200, 10'd200, 10'd200);
    pix(1'b1);
    repeat (6) pulse(1'b1);
    chk("vslow7", int'(man_addr), 0);
    pulse(1'b1);
    chk("vslow8", int'(man_addr), 50);

    // Randomized traffic against the model.
    rv = 1'b1; rd = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rv = ~rv;
      if (rd) begin
        if ($urandom_range(0, 299) == 0) rd = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        rd = 1'b1;
      end
      rmx = 10'($urandom_range(0, 1023));
      rmy = 10'($urandom_range(0, 1023));
      cyc(rv, rd, rmx + 10'($urandom_range(0, 24)) - 10'd2,
          rmy + 10'($urandom_range(0, 24)) - 10'd2, rmx, rmy);
    end

    // Asynchronous reset mid-stream.
    pulse(1'b1);
    cyc(1'b1, 1'b1, 10'd205, 10'd203, 10'd200, 10'd200);
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_addr", int'(man_addr), 0);
    chk("rst_dx", int'(DrawX_d), 0);
    chk("rst_dy", int'(DrawY_d), 0);
    chk("rst_mx", int'(ManX_d), 0);
    chk("rst_my", int'(ManY_d), 0);
    chk("rst_on", int'(man_on_d), 0);
    chk("rst_done", int'(anim_done), 0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    pix(1'b1);
    pix(1'b1);
    pix(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
